// File: rtl/gpu_apb_cmd_master.sv
// APB write initiator for the GPU command port. Buffers host command words in a small FIFO
// and replays each one, in push order, as a 2-cycle APB write to a fixed command address.
module gpu_apb_cmd_master #(
  parameter int          FIFO_DEPTH     = 4,
  parameter int          FIFO_ADDR_BITS = 2,
  parameter logic [31:0] CMD_ADDR       = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [31:0]               cmd_data_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      pause_i,
  output logic [31:0]               pAddr_o,
  output logic [31:0]               pDataWrite_o,
  output logic                      pSel_o,
  output logic                      pEnable_o,
  output logic                      pWrite_o,
  output logic [FIFO_ADDR_BITS:0]   pending_o,
  output logic                      idle_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [FIFO_ADDR_BITS:0] CNT_ONE   = (FIFO_ADDR_BITS+1)'(1);
  localparam logic [FIFO_ADDR_BITS:0] CNT_DEPTH = (FIFO_ADDR_BITS+1)'(FIFO_DEPTH);

  state_t                    state, state_nxt;
  logic [31:0]               mem [FIFO_DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
  logic [FIFO_ADDR_BITS:0]   count;
  logic                      push, pop;
  logic [31:0]               head_nxt;

  assign cmd_ready_o = (count < CNT_DEPTH);
  assign push        = cmd_valid_i && cmd_ready_o;
  assign pop         = (state == ACCESS);
  assign rd_ptr_inc  = rd_ptr + 1'b1;
  assign pending_o   = count;
  assign idle_o      = (state == IDLE) && (count == '0);

  // A transfer entering SETUP from ACCESS sees the word behind the one being popped.
  assign head_nxt = pop ? mem[rd_ptr_inc] : mem[rd_ptr];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0 && !pause_i) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  state_nxt = (count > CNT_ONE && !pause_i) ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_data_i;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr_inc;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // APB outputs are registered from the next state so they change cleanly on the edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pSel_o       <= 1'b0;
      pEnable_o    <= 1'b0;
      pWrite_o     <= 1'b0;
      pAddr_o      <= '0;
      pDataWrite_o <= '0;
    end else begin
      case (state_nxt)
        SETUP: begin
          pSel_o       <= 1'b1;
          pEnable_o    <= 1'b0;
          pWrite_o     <= 1'b1;
          pAddr_o      <= CMD_ADDR;
          pDataWrite_o <= head_nxt;
        end
        ACCESS: begin
          pSel_o    <= 1'b1;
          pEnable_o <= 1'b1;
          pWrite_o  <= 1'b1;
        end
        default: begin
          pSel_o       <= 1'b0;
          pEnable_o    <= 1'b0;
          pWrite_o     <= 1'b0;
          pAddr_o      <= '0;
          pDataWrite_o <= '0;
        end
      endcase
    end
  end

endmodule
